read_arbiter_core: RTL

READ_ARBITER_CORE -- requirements
Module: read_arbiter_core

---
 rtl/read_arbiter_core.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/read_arbiter_core.sv
// Read arbiter: picks one of NUM_PORTS requesters (strict priority or round-robin)
// and holds the grant for one packet read. Optional watchdog under READ_ARB_TIMEOUT_EN.
module read_arbiter_core #(
  parameter int NUM_PORTS = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sp0_rr1,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS*3-1:0] priority_in,
  input  logic                   rd_valid,
  input  logic                   rd_eop,
  output logic [3:0]             grant_port,
  output logic                   grant_valid,
  output logic                   rd_start,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_port_q, grant_port_d;
  logic [3:0] last_q, last_d;
  logic       grant_valid_q, grant_valid_d;
  logic       rd_start_q, rd_start_d;
  logic       busy_q, busy_d;

  logic [3:0] win_port;
  logic       win_found;
  logic [2:0] best_pri;
  logic [2:0] cur_pri;
  logic       cur_req;
  logic [4:0] rr_raw;
  logic [4:0] rr_idx;

`ifdef READ_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  // Winner selection; evaluated every cycle but only consumed in ARB.
  always_comb begin
    win_port  = 4'd0;
    win_found = 1'b0;
    best_pri  = 3'd0;
    cur_pri   = 3'd0;
    cur_req   = 1'b0;
    rr_raw    = 5'd0;
    rr_idx    = 5'd0;
    if (sp0_rr1) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        rr_raw  = 5'(last_q) + 5'd1 + 5'(k);
        rr_idx  = (rr_raw >= 5'(NUM_PORTS)) ? (rr_raw - 5'(NUM_PORTS)) : rr_raw;
        cur_req = 1'(req >> rr_idx);
        if (cur_req && !win_found) begin
          win_found = 1'b1;
          win_port  = rr_idx[3:0];
        end else begin
          win_found = win_found;
        end
      end
    end else begin
      // Strict '>' keeps the lowest index on equal priority.
      for (int i = 0; i < NUM_PORTS; i++) begin
        cur_req = 1'(req >> i);
        cur_pri = 3'(priority_in >> (3 * i));
        if (cur_req && (!win_found || (cur_pri > best_pri))) begin
          win_found = 1'b1;
          best_pri  = cur_pri;
          win_port  = 4'(i);
        end else begin
          win_found = win_found;
        end
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    grant_port_d  = grant_port_q;
    grant_valid_d = grant_valid_q;
    rd_start_d    = 1'b0;
    last_d        = last_q;
`ifdef READ_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
        else      state_d = S_IDLE;
      end
      S_ARB: begin
        if (win_found) begin
          state_d       = S_XFER;
          grant_port_d  = win_port;
          grant_valid_d = 1'b1;
          rd_start_d    = 1'b1;
`ifdef READ_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (rd_valid && rd_eop) begin
          state_d = S_DONE;
`ifdef READ_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = S_DONE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`else
        end else begin
          state_d = S_XFER;
`endif
        end
      end
      S_DONE: begin
        state_d       = S_IDLE;
        grant_valid_d = 1'b0;
        last_d        = grant_port_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      grant_port_q  <= 4'd0;
      grant_valid_q <= 1'b0;
      rd_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      last_q        <= 4'(NUM_PORTS - 1);
`ifdef READ_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_port_q  <= grant_port_d;
      grant_valid_q <= grant_valid_d;
      rd_start_q    <= rd_start_d;
      busy_q        <= busy_d;
      last_q        <= last_d;
`ifdef READ_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant_port  = grant_port_q;
  assign grant_valid = grant_valid_q;
  assign rd_start    = rd_start_q;
  assign busy        = busy_q;
`ifdef READ_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
